count_checker: RTL and testbench



---
 rtl/count_checker.sv | 99 +++++++++
 tb/tb_count_checker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// count_checker: locks onto a counter's count bus and flags any sample that is not the previous sample plus one.
// Tracks mismatches and wraps, keeps the first failure, and halts after MAX_ERR mismatches.
module count_checker #(
    parameter int N_BITS  = 8,
    parameter int CNT_W   = 16,
    parameter int MAX_ERR = 4
) (
    input  logic              clk,
    input  logic              asyn_n_rst,
    input  logic [N_BITS-1:0] count_in,
    input  logic              sample_en,
    input  logic              clr,
    output logic              locked,
    output logic              halted,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  wrap_cnt,
    output logic [N_BITS-1:0] first_exp,
    output logic [N_BITS-1:0] first_got
);
    typedef enum logic [1:0] {IDLE, TRACK, HALT} state_t;
    localparam logic [N_BITS-1:0] TOP = '1;
    state_t state, state_nx;
    logic [N_BITS-1:0] exp_q, exp_nx, first_exp_nx, first_got_nx;
    logic [CNT_W-1:0] err_nx, wrap_nx, err_sat, wrap_sat;
    logic sticky_nx, pulse_nx, hit, miss, halt_now;

    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        hit      = count_in == exp_q;
        miss     = state == TRACK && sample_en && !hit;
        err_sat  = &err_cnt ? err_cnt : err_cnt + 1'b1;
        wrap_sat = &wrap_cnt ? wrap_cnt : wrap_cnt + 1'b1;
        // Compare against the post-increment count so the MAX_ERR-th miss halts
        halt_now = MAX_ERR != 0 && 32'(err_sat) >= 32'(MAX_ERR);
        state_nx = state;
        if (clr) state_nx = IDLE;
        else if (sample_en && state == IDLE) state_nx = TRACK;
        else if (miss && halt_now) state_nx = HALT;
    end

    always_comb begin
        exp_nx       = exp_q;
        err_nx       = err_cnt;
        wrap_nx      = wrap_cnt;
        sticky_nx    = err_sticky;
        first_exp_nx = first_exp;
        first_got_nx = first_got;
        pulse_nx     = 1'b0;
        if (clr) begin
            exp_nx       = '0;
            err_nx       = '0;
            wrap_nx      = '0;
            sticky_nx    = 1'b0;
            first_exp_nx = '0;
            first_got_nx = '0;
        end else if (sample_en && state != HALT) begin
            exp_nx = count_in + 1'b1;
            if (state == TRACK && hit && count_in == TOP) wrap_nx = wrap_sat;
            if (miss) begin
                pulse_nx     = 1'b1;
                err_nx       = err_sat;
                sticky_nx    = 1'b1;
                first_exp_nx = err_sticky ? first_exp : exp_q;
                first_got_nx = err_sticky ? first_got : count_in;
            end
        end
    end

    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            exp_q      <= '0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
            err_sticky <= 1'b0;
            err_pulse  <= 1'b0;
            first_exp  <= '0;
            first_got  <= '0;
        end else begin
            exp_q      <= exp_nx;
            err_cnt    <= err_nx;
            wrap_cnt   <= wrap_nx;
            err_sticky <= sticky_nx;
            err_pulse  <= pulse_nx;
            first_exp  <= first_exp_nx;
            first_got  <= first_got_nx;
        end
    end

    always_comb begin
        locked = state != IDLE;
        halted = state == HALT;
    end
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: scoreboard bench for count_checker (N_BITS=3, MAX_ERR=2) plus a saturation instance (CNT_W=2, MAX_ERR=0).
module tb_count_checker;
    logic clk = 0, rst_n = 0, en = 0, clr = 0, en2 = 0;
    logic [2:0] cin = 0, cin2 = 0;
    logic locked, halted, err_pulse, err_sticky, locked2, halted2, pulse2, sticky2;
    logic [15:0] err_cnt, wrap_cnt;
    logic [1:0] err2, wrap2;
    logic [2:0] first_exp, first_got, fe2, fg2;
    logic [41:0] obs, e;
    logic [41:0] q[$];
    int tests = 0, fails = 0;
    int ms;
    logic [2:0] mexp, mfe, mfg;
    logic [15:0] merr, mwrap;
    logic mst, mpulse;

    count_checker #(.N_BITS(3), .CNT_W(16), .MAX_ERR(2)) dut (
        .clk(clk), .asyn_n_rst(rst_n), .count_in(cin), .sample_en(en), .clr(clr),
        .locked(locked), .halted(halted), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .first_exp(first_exp), .first_got(first_got));

    count_checker #(.N_BITS(3), .CNT_W(2), .MAX_ERR(0)) dut2 (
        .clk(clk), .asyn_n_rst(rst_n), .count_in(cin2), .sample_en(en2), .clr(1'b0),
        .locked(locked2), .halted(halted2), .err_pulse(pulse2), .err_sticky(sticky2),
        .err_cnt(err2), .wrap_cnt(wrap2), .first_exp(fe2), .first_got(fg2));

    assign obs = {locked, halted, err_pulse, err_sticky, err_cnt, wrap_cnt, first_exp, first_got};
    always #5 clk = ~clk;

    task automatic model_reset();
        ms = 0; mexp = 0; merr = 0; mwrap = 0; mst = 0; mfe = 0; mfg = 0; mpulse = 0;
    endtask

    task automatic drive(input logic s_en, input logic [2:0] v, input logic s_clr);
        en = s_en; cin = v; clr = s_clr;
        mpulse = 0;
        if (s_clr) model_reset();
        else if (s_en && ms == 0) begin mexp = v + 3'd1; ms = 1; end
        else if (s_en && ms == 1) begin
            if (v == mexp) begin
                if (v == 3'd7 && mwrap != 16'hffff) mwrap = mwrap + 1;
            end else begin
                mpulse = 1;
                if (merr != 16'hffff) merr = merr + 1;
                if (!mst) begin mfe = mexp; mfg = v; end
                mst = 1;
                if (merr >= 2) ms = 2;
            end
            mexp = v + 3'd1;
        end
        q.push_back({ms != 0, ms == 2, mpulse, mst, merr, mwrap, mfe, mfg});
        @(posedge clk); #1;
        en = 0; clr = 0;
    endtask

    task automatic test_reset();
        #3;
        tests++; if (obs !== 42'd0) begin fails++; $display("FAIL reset obs=%h exp=0", obs); end
        tests++; if ({locked2, halted2, pulse2, sticky2, err2, wrap2, fe2, fg2} !== 16'd0) begin
            fails++; $display("FAIL reset2 got nonzero"); end
        #4 rst_n = 1;
        model_reset();
    endtask

    task automatic test_count_up();
        for (int i = 0; i < 16; i++) begin
            drive(1, 3'(i), 0);
            e = q.pop_front();
            tests++; if (obs !== e) begin fails++; $display("FAIL count_up[%0d] obs=%h exp=%h", i, obs, e); end
            if (i == 0) begin tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock got=%b exp=1", locked); end end
        end
        tests++; if (err_cnt !== 16'd0 || wrap_cnt !== 16'd2 || err_sticky !== 1'b0) begin
            fails++; $display("FAIL count_up_end err=%0d wrap=%0d st=%b exp 0/2/0", err_cnt, wrap_cnt, err_sticky); end
    endtask

    task automatic test_mismatch();
        logic [2:0] s[4] = '{3, 4, 6, 7};
        drive(0, 0, 1); e = q.pop_front();
        tests++; if (obs !== e) begin fails++; $display("FAIL clr1 obs=%h exp=%h", obs, e); end
        foreach (s[i]) begin
            drive(1, s[i], 0); e = q.pop_front();
            tests++; if (obs !== e) begin fails++; $display("FAIL mismatch[%0d] obs=%h exp=%h", i, obs, e); end
            if (i == 2) begin
                tests++; if (err_pulse !== 1 || err_cnt !== 1 || first_exp !== 5 || first_got !== 6) begin
                    fails++; $display("FAIL mis6 pulse=%b err=%0d fe=%0d fg=%0d exp 1/1/5/6", err_pulse, err_cnt, first_exp, first_got); end
            end
        end
        tests++; if (err_pulse !== 0 || wrap_cnt !== 1) begin
            fails++; $display("FAIL resync pulse=%b wrap=%0d exp 0/1", err_pulse, wrap_cnt); end
    endtask

    task automatic test_gaps();
        drive(0, 0, 1); void'(q.pop_front());
        drive(1, 1, 0); void'(q.pop_front());
        drive(1, 2, 0); void'(q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive(0, 5, 0); e = q.pop_front();
            tests++; if (obs !== e) begin fails++; $display("FAIL gap[%0d] obs=%h exp=%h", i, obs, e); end
        end
        drive(1, 3, 0); e = q.pop_front();
        tests++; if (obs !== e || err_cnt !== 0) begin fails++; $display("FAIL gap_end obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_halt();
        logic [2:0] s[5] = '{2, 5, 6, 0, 4};
        drive(0, 0, 1); void'(q.pop_front());
        foreach (s[i]) begin
            drive(1, s[i], 0); e = q.pop_front();
            tests++; if (obs !== e) begin fails++; $display("FAIL halt[%0d] obs=%h exp=%h", i, obs, e); end
        end
        tests++; if (err_cnt !== 2 || halted !== 1 || first_exp !== 3 || first_got !== 5) begin
            fails++; $display("FAIL halt_end err=%0d h=%b fe=%0d fg=%0d exp 2/1/3/5", err_cnt, halted, first_exp, first_got); end
    endtask

    task automatic test_clr_in_halt();
        drive(1, 2, 1); e = q.pop_front();
        tests++; if (obs !== 42'd0 || obs !== e) begin fails++; $display("FAIL clr_halt obs=%h exp=0", obs); end
        drive(1, 4, 0); e = q.pop_front();
        tests++; if (obs !== e || locked !== 1) begin fails++; $display("FAIL relock obs=%h exp=%h", obs, e); end
        drive(1, 5, 0); e = q.pop_front();
        tests++; if (obs !== e) begin fails++; $display("FAIL relock2 obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_async_reset();
        drive(1, 7, 0); void'(q.pop_front());
        drive(1, 1, 0); void'(q.pop_front());
        #2 rst_n = 0;
        #1;
        tests++; if (obs !== 42'd0) begin fails++; $display("FAIL async_rst obs=%h exp=0", obs); end
        rst_n = 1; model_reset();
        drive(1, 6, 0); e = q.pop_front();
        tests++; if (obs !== e || locked !== 1 || err_cnt !== 0) begin fails++; $display("FAIL rst_relock obs=%h exp=%h", obs, e); end
    endtask

    task automatic test_saturate();
        logic [2:0] s[6] = '{0, 3, 6, 1, 4, 7};
        foreach (s[i]) begin
            en2 = 1; cin2 = s[i];
            @(posedge clk); #1;
            en2 = 0;
        end
        tests++; if (err2 !== 2'd3 || halted2 !== 0 || fe2 !== 1 || fg2 !== 3 || sticky2 !== 1) begin
            fails++; $display("FAIL saturate err=%0d h=%b fe=%0d fg=%0d exp 3/0/1/3", err2, halted2, fe2, fg2); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_count_up();
        test_mismatch();
        test_gaps();
        test_halt();
        test_clr_in_halt();
        test_async_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
